// File: rtl/mux2_resp_checker.sv
// Response checker for a 2:1 mux datapath: aligns expected vs. observed output over LATENCY cycles,
// counts vectors/mismatches and reports pass/fail. Optional macro: MUX2_CHK_STOP_ON_ERR_EN (stop run on first mismatch).
module mux2_resp_checker #(
   parameter int LATENCY   = 1,
   parameter int N_VECTORS = 255,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             vld_i,
   input  logic             a_i,
   input  logic             b_i,
   input  logic             sel_i,
   input  logic             out_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic             err_o,
   output logic [CNT_W-1:0] vec_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic [CNT_W-1:0] first_err_idx_o,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] N_LIM   = CNT_W'(N_VECTORS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] first_idx_q, first_idx_d;
   logic             err_q, err_d;

   logic run_start;
   logic capture;
   logic exp_in;
   logic cmp_vld;
   logic cmp_exp;
   logic stop_hit;
   logic halt;
   logic cmp_en;
   logic mismatch;

   assign run_start = start && (state_q != ST_RUN);
   assign capture   = vld_i && (state_q == ST_RUN);
   assign exp_in    = sel_i ? b_i : a_i;

`ifdef MUX2_CHK_STOP_ON_ERR_EN
   assign stop_hit = err_q;
`else
   assign stop_hit = 1'b0;
`endif

   // Once the run limit is reached, anything still in flight is dropped.
   assign halt     = (vec_cnt_q == N_LIM) || stop_hit;
   assign cmp_en   = (state_q == ST_RUN) && cmp_vld && !halt;
   assign mismatch = cmp_en && (out_i !== cmp_exp);

   generate
      if (LATENCY == 0) begin : g_comb
         assign cmp_vld = capture;
         assign cmp_exp = exp_in;
      end else begin : g_pipe
         logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
         logic [LATENCY-1:0] pipe_exp_q, pipe_exp_d;

         always_comb begin
            pipe_vld_d = '0;
            pipe_exp_d = pipe_exp_q;
            if (!run_start) begin
               pipe_vld_d[0] = capture;
               pipe_exp_d[0] = exp_in;
               for (int i = 1; i < LATENCY; i++) begin
                  pipe_vld_d[i] = pipe_vld_q[i-1];
                  pipe_exp_d[i] = pipe_exp_q[i-1];
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pipe_vld_q <= '0;
               pipe_exp_q <= '0;
            end else begin
               pipe_vld_q <= pipe_vld_d;
               pipe_exp_q <= pipe_exp_d;
            end
         end

         assign cmp_vld = pipe_vld_q[LATENCY-1];
         assign cmp_exp = pipe_exp_q[LATENCY-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (halt)  state_d = ST_DONE;
         ST_DONE: if (start) state_d = ST_RUN;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o      = (state_q == ST_RUN);
      done_o      = (state_q == ST_DONE);
      pass_o      = (state_q == ST_DONE) && (err_cnt_q == '0);
      dbg_state_o = state_q;
   end

   always_comb begin
      vec_cnt_d   = vec_cnt_q;
      err_cnt_d   = err_cnt_q;
      first_idx_d = first_idx_q;
      err_d       = err_q;
      if (run_start) begin
         vec_cnt_d   = '0;
         err_cnt_d   = '0;
         first_idx_d = '0;
         err_d       = 1'b0;
      end else if (cmp_en) begin
         vec_cnt_d = vec_cnt_q + CNT_ONE;
         if (mismatch) begin
            err_d = 1'b1;
            if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
            if (!err_q) first_idx_d = vec_cnt_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_cnt_q   <= '0;
         err_cnt_q   <= '0;
         first_idx_q <= '0;
         err_q       <= 1'b0;
      end else begin
         vec_cnt_q   <= vec_cnt_d;
         err_cnt_q   <= err_cnt_d;
         first_idx_q <= first_idx_d;
         err_q       <= err_d;
      end
   end

   assign vec_cnt_o       = vec_cnt_q;
   assign err_cnt_o       = err_cnt_q;
   assign first_err_idx_o = first_idx_q;
   assign err_o           = err_q;

endmodule

// File: tb/tb_mux2_resp_checker.sv
// Bench for mux2_resp_checker: four checker instances with different latency/limit/width settings,
// fed by a bench-side mux whose output can be flipped per vector. Honors MUX2_CHK_STOP_ON_ERR_EN.
module tb_mux2_resp_checker;

`ifdef MUX2_CHK_STOP_ON_ERR_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif
   localparam int W = 50;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic vld = 1'b0, a = 1'b0, b = 1'b0, sel = 1'b0, flip = 1'b0;
   logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0;
   logic mux_now, mux_d1 = 1'b0, mux_d2 = 1'b0;
   int   cyc = 0;

   assign mux_now = (sel ? b : a) ^ flip;
   always @(posedge clk) begin
      mux_d1 <= mux_now;
      mux_d2 <= mux_d1;
      cyc    <= cyc + 1;
   end

   logic        busy_a, done_a, pass_a, err_a, busy_b, done_b, pass_b, err_b;
   logic        busy_c, done_c, pass_c, err_c, busy_d, done_d, pass_d, err_d;
   logic [15:0] vec_a, ecnt_a, first_a, vec_b, ecnt_b, first_b, vec_d, ecnt_d, first_d;
   logic [1:0]  vec_c, ecnt_c, first_c;
   logic [1:0]  st_a, st_b, st_c, st_d;

   mux2_resp_checker #(.LATENCY(1), .N_VECTORS(4), .CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .vld_i(vld), .a_i(a), .b_i(b), .sel_i(sel),
      .out_i(mux_d1), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .err_o(err_a),
      .vec_cnt_o(vec_a), .err_cnt_o(ecnt_a), .first_err_idx_o(first_a), .dbg_state_o(st_a));
   mux2_resp_checker #(.LATENCY(0), .N_VECTORS(255), .CNT_W(16)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .vld_i(vld), .a_i(a), .b_i(b), .sel_i(sel),
      .out_i(mux_now), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .err_o(err_b),
      .vec_cnt_o(vec_b), .err_cnt_o(ecnt_b), .first_err_idx_o(first_b), .dbg_state_o(st_b));
   mux2_resp_checker #(.LATENCY(2), .N_VECTORS(3), .CNT_W(2)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .vld_i(vld), .a_i(a), .b_i(b), .sel_i(sel),
      .out_i(mux_d2), .busy_o(busy_c), .done_o(done_c), .pass_o(pass_c), .err_o(err_c),
      .vec_cnt_o(vec_c), .err_cnt_o(ecnt_c), .first_err_idx_o(first_c), .dbg_state_o(st_c));
   mux2_resp_checker #(.LATENCY(1), .N_VECTORS(8), .CNT_W(16)) u_d (
      .clk(clk), .rst_n(rst_n), .start(start_d), .vld_i(vld), .a_i(a), .b_i(b), .sel_i(sel),
      .out_i(mux_d1), .busy_o(busy_d), .done_o(done_d), .pass_o(pass_d), .err_o(err_d),
      .vec_cnt_o(vec_d), .err_cnt_o(ecnt_d), .first_err_idx_o(first_d), .dbg_state_o(st_d));

   int          cur = 0;
   logic        cur_busy, cur_done, cur_pass, cur_err;
   logic [15:0] cur_vec, cur_ecnt, cur_first;
   logic [1:0]  cur_st;

   always_comb begin
      {cur_busy, cur_done, cur_pass, cur_err, cur_vec, cur_ecnt, cur_first, cur_st} =
         {busy_a, done_a, pass_a, err_a, vec_a, ecnt_a, first_a, st_a};
      case (cur)
         1: {cur_busy, cur_done, cur_pass, cur_err, cur_vec, cur_ecnt, cur_first, cur_st} =
               {busy_b, done_b, pass_b, err_b, vec_b, ecnt_b, first_b, st_b};
         2: {cur_busy, cur_done, cur_pass, cur_err, cur_vec, cur_ecnt, cur_first, cur_st} =
               {busy_c, done_c, pass_c, err_c, 14'd0, vec_c, 14'd0, ecnt_c, 14'd0, first_c, st_c};
         3: {cur_busy, cur_done, cur_pass, cur_err, cur_vec, cur_ecnt, cur_first, cur_st} =
               {busy_d, done_d, pass_d, err_d, vec_d, ecnt_d, first_d, st_d};
         default: ;
      endcase
   end

   logic [W-1:0] exp_q[$];
   bit           stim_a[0:299], stim_b[0:299], stim_s[0:299], stim_bad[0:299];
   int           n_cmp = 0;
   int           n_bad = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, act, exp);
      end
   endtask

   task automatic set_start(input int inst, input logic v);
      case (inst)
         0: start_a = v;
         1: start_b = v;
         2: start_c = v;
         default: start_d = v;
      endcase
   endtask

   // Reference result of one run: {pass, err, vec_cnt, err_cnt, first_err_idx}.
   function automatic logic [W-1:0] model(input int n_lim, input int cnt_w, input int n_drive);
      int vc = 0, ec = 0, fi = 0;
      int sat = (1 << cnt_w) - 1;
      bit er = 1'b0;
      for (int i = 0; i < n_drive; i++) begin
         if (vc == n_lim) break;
         if (STOP && er) break;
         if (stim_bad[i]) begin
            if (!er) fi = vc;
            er = 1'b1;
            if (ec < sat) ec++;
         end
         vc++;
      end
      return {(ec == 0), er, vc[15:0], ec[15:0], fi[15:0]};
   endfunction

   task automatic fill(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         stim_a[i]   = rnd ? 1'($urandom_range(0, 1)) : stim_a[i];
         stim_b[i]   = rnd ? 1'($urandom_range(0, 1)) : stim_b[i];
         stim_s[i]   = rnd ? 1'($urandom_range(0, 1)) : stim_s[i];
         stim_bad[i] = 1'b0;
      end
   endtask

   task automatic run_vectors(input int inst, input int n_lim, input int cnt_w, input int n_drive,
                              input int restart_at, input int exp_lat);
      logic [W-1:0] e;
      int t0 = 0, lat = 0;
      bit seen = 1'b0;
      cur = inst;
      exp_q.push_back(model(n_lim, cnt_w, n_drive));
      // A deliberately wrong vector rides along with start; it must not be captured.
      set_start(inst, 1'b1);
      vld = 1'b1; a = 1'b1; b = 1'b0; sel = 1'b0; flip = 1'b1;
      @(negedge clk);
      set_start(inst, 1'b0);
      for (int c = 0; c < n_drive + 16 && !seen; c++) begin
         if (c == 0) check("busy_run", cur_busy, 1);
         if (cur_done) begin
            seen = 1'b1;
            lat  = cyc - t0 - 1;
         end else begin
            if (c < n_drive) begin
               vld = 1'b1; a = stim_a[c]; b = stim_b[c]; sel = stim_s[c]; flip = stim_bad[c];
               if (c == 0) t0 = cyc;
               if (c == restart_at) set_start(inst, 1'b1);
            end else begin
               vld = 1'b0; flip = 1'b0;
            end
            @(negedge clk);
            set_start(inst, 1'b0);
         end
      end
      vld = 1'b0; flip = 1'b0;
      if (!seen) check("done_timeout", 0, 1);
      else if (exp_lat >= 0) check("done_latency", lat, exp_lat);
      if (exp_q.size() == 0) begin
         check("sb_empty", 0, 1);
      end else begin
         e = exp_q.pop_front();
         check("vec_cnt", cur_vec, e[47:32]);
         check("err_cnt", cur_ecnt, e[31:16]);
         check("first_idx", cur_first, e[15:0]);
         check("err", cur_err, e[48]);
         check("pass", cur_pass, e[49]);
         check("busy_done", cur_busy, 0);
      end
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_busy"}, cur_busy, 0);
      check({tag, "_done"}, cur_done, 0);
      check({tag, "_pass"}, cur_pass, 0);
      check({tag, "_err"}, cur_err, 0);
      check({tag, "_vec"}, cur_vec, 0);
      check({tag, "_ecnt"}, cur_ecnt, 0);
      check({tag, "_first"}, cur_first, 0);
      check({tag, "_state"}, cur_st, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      cur = 0;
      check_cleared("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Directed run, ideal mux, then same run with vector 2 corrupted.
      stim_a[0] = 1; stim_b[0] = 0; stim_s[0] = 0;
      stim_a[1] = 0; stim_b[1] = 1; stim_s[1] = 1;
      stim_a[2] = 1; stim_b[2] = 1; stim_s[2] = 0;
      stim_a[3] = 0; stim_b[3] = 0; stim_s[3] = 1;
      fill(4, 1'b0);
      run_vectors(0, 4, 16, 4, -1, 5);
      stim_bad[2] = 1'b1;
      run_vectors(0, 4, 16, 4, -1, -1);

      // Zero latency, random vectors beyond the limit, then restart from DONE.
      fill(257, 1'b1);
      run_vectors(1, 255, 16, 257, -1, -1);
      set_start(1, 1'b1);
      @(negedge clk);
      set_start(1, 1'b0);
      check("restart_vec", cur_vec, 0);
      check("restart_ecnt", cur_ecnt, 0);
      check("restart_busy", cur_busy, 1);
      check("restart_done", cur_done, 0);

      // Narrow counters, every vector wrong.
      fill(3, 1'b1);
      for (int i = 0; i < 3; i++) stim_bad[i] = 1'b1;
      run_vectors(2, 3, 2, 3, -1, -1);

      // Single error at index 3 of 8.
      fill(8, 1'b1);
      stim_bad[3] = 1'b1;
      run_vectors(3, 8, 16, 8, -1, -1);

      // vld in IDLE is ignored.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cur = 0;
      vld = 1'b1; a = 1'b1; b = 1'b0; sel = 1'b0; flip = 1'b1;
      repeat (3) @(negedge clk);
      vld = 1'b0; flip = 1'b0;
      @(negedge clk);
      check_cleared("idle_vld");

      // start during RUN is ignored.
      fill(4, 1'b1);
      run_vectors(0, 4, 16, 4, 1, 5);

      // Asynchronous reset mid-run discards a partial result.
      fill(4, 1'b1);
      stim_bad[0] = 1'b1;
      set_start(0, 1'b1);
      @(negedge clk);
      set_start(0, 1'b0);
      for (int c = 0; c < 10 && cur_vec != 16'd2; c++) begin
         vld = 1'b1; a = stim_a[c]; b = stim_b[c]; sel = stim_s[c]; flip = stim_bad[c];
         @(negedge clk);
      end
      vld = 1'b0; flip = 1'b0;
      check("pre_reset_vec", cur_vec, 2);
      check("pre_reset_err", cur_err, 1);
      #2 rst_n = 1'b0;
      #1 check_cleared("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mux2_resp_checker.md
Name: mux2_resp_checker

Overview:
- Synthesizable response checker that sits at the output end of a 2:1 mux datapath.
- Samples each applied vector (a, b, sel) and the observed mux output, and computes the expected output.
- Aligns expected and observed over a configurable pipeline latency.
- Counts vectors and mismatches, then reports pass/fail after a fixed number of vectors.
- Used on-chip and in simulation, paired with a random stimulus source.

Parameters:
- LATENCY, 1, cycles from vector acceptance to valid out_i; legal range 0..4.
- N_VECTORS, 255, vectors checked per run; legal range 1..2^CNT_W-1.
- CNT_W, 16, width of the vector counter, error counter and first-error index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a run.
- vld_i  input  1  a_i/b_i/sel_i carry a new vector this cycle.
- a_i  input  1  mux input a applied to the DUT.
- b_i  input  1  mux input b applied to the DUT.
- sel_i  input  1  mux select applied to the DUT; 0 selects a, 1 selects b.
- out_i  input  1  observed mux output.
- busy_o  output  1  run in progress.
- done_o  output  1  run finished; sticky until the next start or reset.
- pass_o  output  1  valid when done_o=1; high iff err_cnt_o==0.
- err_o  output  1  sticky; set on the first mismatch of a run.
- vec_cnt_o  output  CNT_W  vectors compared in the current run.
- err_cnt_o  output  CNT_W  mismatches in the current run; saturates at all-ones.
- first_err_idx_o  output  CNT_W  vec_cnt value at the first mismatch.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; FSM in IDLE; pipeline valid bits 0.
- Reset mid-run aborts the run immediately with no partial result retained.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE in the cycle after the compare that makes vec_cnt_o equal N_VECTORS.
- DONE -> RUN on start=1. No other exit from DONE except reset.
- start while in RUN is ignored.
- On the start edge (IDLE or DONE):
  - clear vec_cnt_o, err_cnt_o, err_o and first_err_idx_o;
  - clear done_o and pass_o;
  - flush the expected pipeline (all valid bits to 0).
- Expected value: exp = sel_i ? b_i : a_i.
- The expected value is captured when vld_i=1 and the FSM is in RUN (including the cycle start is seen from IDLE/DONE: that vector is not captured).
- vld_i in IDLE or DONE is ignored.
- Alignment:
  - LATENCY=0: exp and its valid compare combinationally against out_i in the same cycle.
  - LATENCY=L>0: exp and valid pass through an L-stage shift register; the compare occurs when stage L is valid.
  - No backpressure: a vector is accepted every cycle vld_i=1.
- Each compare:
  - vec_cnt_o increments by 1.
  - On out_i != exp: err_cnt_o increments (saturating) and err_o is set.
  - On the first mismatch: first_err_idx_o = vec_cnt_o before increment (0-based).
- Compares stop once vec_cnt_o == N_VECTORS. In-flight pipeline entries are discarded.
- Vectors accepted beyond N_VECTORS are still captured and are then discarded.
- In DONE: busy_o=0, done_o=1, pass_o=(err_cnt_o==0).
- busy_o=1 exactly while in RUN.
- Counters hold their values in IDLE and DONE.
- out_i carrying X/Z in simulation counts as a mismatch (4-state != comparison).

Optional Feature:
- Macro: MUX2_CHK_STOP_ON_ERR_EN.
- Defined: the first mismatch moves RUN -> DONE on the next cycle.
  - vec_cnt_o freezes at the count including the failing vector.
  - err_cnt_o=1, pass_o=0.
- Undefined: the run always completes N_VECTORS compares, and err_cnt_o accumulates all mismatches.

Test Plan:
- LATENCY=1, N_VECTORS=4. Reset, start, then 4 vectors (a,b,sel) = (1,0,0),(0,1,1),(1,1,0),(0,0,1) with a correct out_i one cycle later -> done_o=1 five cycles after the first vld_i; vec_cnt_o=4, err_cnt_o=0, pass_o=1, err_o=0.
- Same run with out_i forced wrong on vector 2 only -> err_o=1, err_cnt_o=1, first_err_idx_o=2, pass_o=0, vec_cnt_o=4.
- LATENCY=0, N_VECTORS=255, random vectors every cycle with an ideal mux -> done_o after 255 compares, pass_o=1. Re-issue start in DONE -> counters clear to 0, busy_o=1 the next cycle.
- start pulsed during RUN and vld_i pulsed in IDLE -> no effect on FSM or counters. Drop rst_n after 2 compares -> all outputs 0 asynchronously, state IDLE.
- CNT_W=2, N_VECTORS=3, all vectors mismatching -> err_cnt_o=3; with CNT_W=2 and N_VECTORS=3, the saturation check holds at 3.
- MUX2_CHK_STOP_ON_ERR_EN defined, N_VECTORS=8, mismatch on vector index 3 -> DONE with vec_cnt_o=4, err_cnt_o=1, pass_o=0. Without the macro -> vec_cnt_o=8.
